avmm_word_copier: RTL
=====================

Name: avmm_word_copier

Overview:
- Avalon-MM master (initiator) that drives the slave port of the 32-bit x 1024-word on-chip memory.
- Accepts a copy command {src, dst, len} and moves len words from src to dst, one word at a time, with a single outstanding transaction.
- Sits between a control FSM/CPU-side command source and the memory's s1 slave. Used for memory init, relocation and fill in the microarchitecture datapath.

Parameters:
- ADDR_W, 10, word-address width (memory depth = 2**ADDR_W)
- DATA_W, 32, data width; byteenable width = DATA_W/8
- LEN_W, 11, command length width (max len = 2**ADDR_W)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command (high only in IDLE)
- cmd_src  in  ADDR_W  source word address
- cmd_dst  in  ADDR_W  destination word address
- cmd_len  in  LEN_W  number of words to copy
- busy  out  1  copy in progress
- done  out  1  one-cycle pulse when the command completes
- avm_address  out  ADDR_W  master address
- avm_chipselect  out  1  asserted with read or write
- avm_read  out  1  read request
- avm_write  out  1  write request
- avm_byteenable  out  DATA_W/8  always all-ones during writes
- avm_writedata  out  DATA_W  write data
- avm_readdata  in  DATA_W  read data
- avm_readdatavalid  in  1  read data valid
- avm_waitrequest  in  1  slave stall; hold request and signals while high

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is synchronous, active-high, named reset.
  - On reset, all outputs are 0 except cmd_ready=1. Internal state is IDLE; counters and registers are cleared.
  - Reset mid-copy aborts the copy immediately: no done pulse, request signals drop on the next edge, and any pending readdatavalid is ignored.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, FIN.
  - IDLE: cmd_ready=1. On cmd_valid, latch src/dst/len and set remaining=len.
    - len==0: go to FIN.
    - Otherwise: go to RD_REQ and set busy=1.
  - RD_REQ: drive avm_read=1, avm_chipselect=1, avm_address=src_ptr.
    - Stay while avm_waitrequest=1.
    - On a cycle with waitrequest=0, go to RD_WAIT.
  - RD_WAIT: all requests low. On avm_readdatavalid, capture avm_readdata into the data register and go to WR_REQ. Arrival latency is variable (≥1 cycle; the on-chip memory returns data 1 cycle after acceptance).
  - WR_REQ: drive avm_write=1, avm_chipselect=1, avm_address=dst_ptr, avm_writedata=data register, avm_byteenable=all-ones.
    - Hold while waitrequest=1.
    - On acceptance: increment src_ptr and dst_ptr and decrement remaining.
    - remaining==1 before decrement: go to FIN. Otherwise: go to RD_REQ.
  - FIN: done=1 for exactly one cycle, busy=0, go to IDLE.
- Timing and ordering:
  - read and write are never asserted together.
  - Throughput with zero waitrequest and latency 1 is 3 cycles/word. A len=N copy produces its done pulse 3N+1 cycles after the accepting edge.
- Address and length rules:
  - Pointers wrap modulo 2**ADDR_W (e.g. 1023 -> 0).
  - cmd_len > 2**ADDR_W is saturated to 2**ADDR_W.
  - Copies run in ascending order. With overlapping regions where dst > src, the result is the forward-copy semantics; this is defined behaviour, not an error.
- Commands presented while busy are not accepted (cmd_ready=0).
- Unexpected readdatavalid outside RD_WAIT is ignored.

Optional Feature:
- Macro: AVMM_COPIER_CHECKSUM_EN.
- Defined:
  - Adds output port checksum [DATA_W-1:0].
  - checksum is cleared when a command is accepted and adds each written word modulo 2**DATA_W on write acceptance.
  - Its value is stable from the done pulse until the next command is accepted.
  - Reset value is 0.
- Undefined: the port and the adder are absent, and behaviour is otherwise identical.

Decomposition:
- Package avmm_copier_pkg:
  - state enum (IDLE, RD_REQ, RD_WAIT, WR_REQ, FIN)
  - ADDR_W/DATA_W/LEN_W defaults
  - BE_ALL constant
- Sub-module avmm_copier_ptr: address pointer plus remaining-count register with load/advance/wrap, instantiated once, holding both pointers.
- FSM and bus drive stay in the top level.

Test Plan:
- Basic copy:
  - Stimulus: preload words 0..3 = 0x11111111..0x44444444; command src=0, dst=100, len=4; memory model with latency 1 and no waitrequest.
  - Response: words 100..103 equal the source; done pulses at cycle 13 after acceptance; busy is high throughout.
- Zero length:
  - Stimulus: command len=0.
  - Response: no avm_read or avm_write; done pulses on the cycle after acceptance.
- Wrap-around:
  - Stimulus: command src=1022, dst=10, len=4.
  - Response: reads from 1022, 1023, 0, 1 and writes to 10..13, in order.
- Backpressure:
  - Stimulus: random waitrequest (50%) and readdatavalid latency of 1-5 cycles.
  - Response: address and data stay stable while stalled; there is never more than 1 outstanding read; data is correct.
- Reset mid-copy:
  - Stimulus: assert reset in WR_REQ of word 2 of 8.
  - Response: next cycle read/write/chipselect=0, cmd_ready=1, no done pulse. A new command then completes correctly.
- Checksum (AVMM_COPIER_CHECKSUM_EN defined):
  - Stimulus: copy 3 words 0xFFFFFFFF, 0x00000002, 0x00000005.
  - Response: checksum = 0x00000006 at done.

Source files
------------

// File: rtl/avmm_copier_pkg.sv
// Shared types and defaults for the Avalon-MM word copier.
package avmm_copier_pkg;

    localparam int DEFAULT_ADDR_W = 10;
    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_LEN_W  = 11;

    // Byteenable pattern for a full-word write at the default data width
    localparam logic [DEFAULT_DATA_W/8-1:0] BE_ALL = 4'b1111;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        FIN     = 3'd4
    } copier_state_e;

endpackage

// File: rtl/avmm_copier_ptr.sv
// Source/destination word pointers plus remaining-word counter.
// Loaded on command accept, advanced once per accepted write; pointers
// wrap naturally at 2**ADDR_W.
module avmm_copier_ptr
    import avmm_copier_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int LEN_W  = DEFAULT_LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_advance,
    input  logic [ADDR_W-1:0] i_src,
    input  logic [ADDR_W-1:0] i_dst,
    input  logic [LEN_W-1:0]  i_len,
    output logic [ADDR_W-1:0] o_src_ptr,
    output logic [ADDR_W-1:0] o_dst_ptr,
    output logic              o_last
);

    // A copy never needs more than one full pass over the memory
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << ADDR_W;

    logic [ADDR_W-1:0] r_src_ptr;
    logic [ADDR_W-1:0] r_dst_ptr;
    logic [LEN_W-1:0]  r_remaining;
    logic [LEN_W-1:0]  w_len_sat;

    // Clamp oversize command lengths to the memory depth
    always_comb begin
        if (i_len > MAX_LEN) begin
            w_len_sat = MAX_LEN;
        end else begin
            w_len_sat = i_len;
        end
    end

    // Load on accept, step both pointers and the count on each written word
    always_ff @(posedge clk) begin
        if (reset) begin
            r_src_ptr   <= '0;
            r_dst_ptr   <= '0;
            r_remaining <= '0;
        end else if (i_load) begin
            r_src_ptr   <= i_src;
            r_dst_ptr   <= i_dst;
            r_remaining <= w_len_sat;
        end else if (i_advance) begin
            r_src_ptr   <= r_src_ptr + ADDR_W'(1);
            r_dst_ptr   <= r_dst_ptr + ADDR_W'(1);
            r_remaining <= r_remaining - LEN_W'(1);
        end else begin
            r_src_ptr   <= r_src_ptr;
            r_dst_ptr   <= r_dst_ptr;
            r_remaining <= r_remaining;
        end
    end

    assign o_src_ptr = r_src_ptr;
    assign o_dst_ptr = r_dst_ptr;
    assign o_last    = (r_remaining == LEN_W'(1));

endmodule

// File: rtl/avmm_word_copier.sv
// Avalon-MM master that copies len words from src to dst, one word at a
// time with a single outstanding read. Optional running sum of written
// words is enabled by defining AVMM_COPIER_CHECKSUM_EN.
module avmm_word_copier
    import avmm_copier_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int LEN_W  = DEFAULT_LEN_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_src,
    input  logic [ADDR_W-1:0]   cmd_dst,
    input  logic [LEN_W-1:0]    cmd_len,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_chipselect,
    output logic                avm_read,
    output logic                avm_write,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic [DATA_W-1:0]   avm_writedata,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_readdatavalid,
    input  logic                avm_waitrequest
`ifdef AVMM_COPIER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]   checksum
`endif
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [BE_W-1:0] BE_ONES = {BE_W{1'b1}};

    copier_state_e     r_state;
    copier_state_e     w_state_nxt;
    logic [DATA_W-1:0] r_data;
    logic              w_accept;
    logic              w_rd_done;
    logic              w_wr_acc;
    logic              w_last;
    logic [ADDR_W-1:0] w_src_ptr;
    logic [ADDR_W-1:0] w_dst_ptr;

    assign w_accept  = (r_state == IDLE) && cmd_valid;
    assign w_rd_done = (r_state == RD_WAIT) && avm_readdatavalid;
    assign w_wr_acc  = (r_state == WR_REQ) && !avm_waitrequest;

    avmm_copier_ptr #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_ptr (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_accept),
        .i_advance (w_wr_acc),
        .i_src     (cmd_src),
        .i_dst     (cmd_dst),
        .i_len     (cmd_len),
        .o_src_ptr (w_src_ptr),
        .o_dst_ptr (w_dst_ptr),
        .o_last    (w_last)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: read, wait for data, write, repeat until last word
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len == LEN_W'(0)) begin
                        w_state_nxt = FIN;
                    end else begin
                        w_state_nxt = RD_REQ;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RD_REQ: begin
                if (!avm_waitrequest) begin
                    w_state_nxt = RD_WAIT;
                end else begin
                    w_state_nxt = RD_REQ;
                end
            end
            RD_WAIT: begin
                if (avm_readdatavalid) begin
                    w_state_nxt = WR_REQ;
                end else begin
                    w_state_nxt = RD_WAIT;
                end
            end
            WR_REQ: begin
                if (avm_waitrequest) begin
                    w_state_nxt = WR_REQ;
                end else if (w_last) begin
                    w_state_nxt = FIN;
                end else begin
                    w_state_nxt = RD_REQ;
                end
            end
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output decode from the registered state; all requests idle at zero
    always_comb begin
        cmd_ready      = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        avm_address    = '0;
        avm_chipselect = 1'b0;
        avm_read       = 1'b0;
        avm_write      = 1'b0;
        avm_byteenable = '0;
        avm_writedata  = '0;
        case (r_state)
            IDLE: cmd_ready = 1'b1;
            RD_REQ: begin
                busy           = 1'b1;
                avm_read       = 1'b1;
                avm_chipselect = 1'b1;
                avm_address    = w_src_ptr;
            end
            RD_WAIT: busy = 1'b1;
            WR_REQ: begin
                busy           = 1'b1;
                avm_write      = 1'b1;
                avm_chipselect = 1'b1;
                avm_address    = w_dst_ptr;
                avm_byteenable = BE_ONES;
                avm_writedata  = r_data;
            end
            FIN:     done = 1'b1;
            default: cmd_ready = 1'b0;
        endcase
    end

    // Capture the returned word; late or stray data outside RD_WAIT is dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
        end else if (w_rd_done) begin
            r_data <= avm_readdata;
        end else begin
            r_data <= r_data;
        end
    end

`ifdef AVMM_COPIER_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    // Running modulo-2**DATA_W sum of written words, restarted per command
    always_ff @(posedge clk) begin
        if (reset) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= '0;
        end else if (w_wr_acc) begin
            r_checksum <= r_checksum + r_data;
        end else begin
            r_checksum <= r_checksum;
        end
    end

    assign checksum = r_checksum;
`endif

endmodule
